// File: rtl/stream_mux_arb_pkg.sv
// Shared constants and helpers for stream arbiters.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package stream_mux_arb_pkg;

  // Arbitration modes
  localparam int MODE_RR    = 0;
  localparam int MODE_FIXED = 1;

  // Width of an index able to name n channels, never less than one bit
  function automatic int sel_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/stream_mux_arb_arbiter.sv
// Round-robin / fixed-priority arbiter: one-hot grant plus grant index.
// Latency: grant is combinational from req; pointer updates on the edge after advance.
// Backpressure: none internally; caller asserts advance only when the grant is taken.
module rr_arbiter
  import stream_mux_arb_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int MODE     = MODE_RR,
  parameter int SEL_W    = sel_width(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] req,
  input  logic                advance,
  output logic [CHANNELS-1:0] grant,
  output logic [SEL_W-1:0]    grant_idx
);

  logic [SEL_W-1:0] ptr_q;
  logic [SEL_W-1:0] ptr_d;
  logic             found;

  // Grant search: first pass covers indices at or above ptr (all of them in
  // fixed mode), second pass wraps around to the indices below ptr.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (!found && req[i] && (MODE == MODE_FIXED || i >= int'(ptr_q))) begin
        grant[i]  = 1'b1;
        grant_idx = SEL_W'(i);
        found     = 1'b1;
      end
    end
    for (int i = 0; i < CHANNELS; i++) begin
      if (!found && req[i]) begin
        grant[i]  = 1'b1;
        grant_idx = SEL_W'(i);
        found     = 1'b1;
      end
    end
  end

  // Next pointer: one past the winner, wrapping explicitly at the last channel
  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      if (grant_idx == SEL_W'(CHANNELS - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = grant_idx + 1'b1;
      end
    end
  end

  // Pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/stream_mux_arb.sv
// N-channel valid/ready stream mux with arbitration and a one-entry output register.
// Latency: 1 cycle from input transfer to out_valid; 1 beat/cycle sustained.
// Backpressure: in_ready is zero while the register is full and out_ready is low.
module stream_mux_arb
  import stream_mux_arb_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int MODE     = MODE_RR,
  localparam int SEL_W   = sel_width(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_sel,
  input  logic                      out_ready
);

  logic [CHANNELS-1:0] grant;
  logic [SEL_W-1:0]    grant_idx;
  logic                free;
  logic                xfer;
  logic [WIDTH-1:0]    win_data;

  logic                out_valid_q, out_valid_d;
  logic [WIDTH-1:0]    out_data_q,  out_data_d;
  logic [SEL_W-1:0]    out_sel_q,   out_sel_d;

  rr_arbiter #(
    .CHANNELS (CHANNELS),
    .MODE     (MODE),
    .SEL_W    (SEL_W)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (in_valid),
    .advance   (xfer),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Ready/valid glue: the register can take a beat when empty or being drained
  always_comb begin
    free     = !out_valid_q || out_ready;
    in_ready = grant & {CHANNELS{free}};
    xfer     = free && (|in_valid);
  end

  // Winner data select, one-hot OR so no wide index arithmetic is needed
  always_comb begin
    win_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant[i]) begin
        win_data = win_data | in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output register next state: load on transfer, empty on idle drain, else hold
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = win_data;
      out_sel_d   = grant_idx;
    end else if (free) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register; reset discards any held beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_stream_mux_arb.sv
// Bench for stream_mux_arb: one round-robin and one fixed-priority instance.
// Latency: reference model expects the beat one edge after its transfer.
// Backpressure: random out_ready with producers holding until accepted.
module tb_stream_mux_arb;

  localparam int W = 32;
  localparam int C = 4;

  logic           clk;
  logic           rst_n;
  logic [C-1:0]   in_valid_a [2];
  logic [C*W-1:0] in_data_a  [2];
  logic [C-1:0]   in_ready_a [2];
  logic           out_valid_a[2];
  logic [W-1:0]   out_data_a [2];
  logic [1:0]     out_sel_a  [2];
  logic           out_ready_a[2];

  int tests = 0;
  int fails = 0;

  // Reference model state per instance (0 = round-robin, 1 = fixed)
  bit       m_vld [2];
  int       m_dat [2];
  int       m_sel [2];
  int       m_ptr [2];
  int       xfer_ch[2];

  stream_mux_arb #(.WIDTH(W), .CHANNELS(C), .MODE(0)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_a[0]), .in_data(in_data_a[0]), .in_ready(in_ready_a[0]),
    .out_valid(out_valid_a[0]), .out_data(out_data_a[0]), .out_sel(out_sel_a[0]),
    .out_ready(out_ready_a[0])
  );

  stream_mux_arb #(.WIDTH(W), .CHANNELS(C), .MODE(1)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_a[1]), .in_data(in_data_a[1]), .in_ready(in_ready_a[1]),
    .out_valid(out_valid_a[1]), .out_data(out_data_a[1]), .out_sel(out_sel_a[1]),
    .out_ready(out_ready_a[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int m, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s[%0d] observed=%h expected=%h", tag, m, obs, exp);
    end
  endtask

  // Winner under the specified rule: scan from ptr with wrap, or from 0 in fixed mode
  function automatic int model_grant(input int m);
    int start;
    start = (m == 0) ? m_ptr[m] : 0;
    for (int j = 0; j < C; j++) begin
      if (in_valid_a[m][(start + j) % C]) return (start + j) % C;
    end
    return -1;
  endfunction

  function automatic int chan_data(input int m, input int ch);
    return int'(in_data_a[m][ch*W +: W]);
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_vld[m] = 0; m_dat[m] = 0; m_sel[m] = 0; m_ptr[m] = 0;
    end
  endtask

  task automatic set_all(input logic [C-1:0] v, input bit rdy);
    for (int m = 0; m < 2; m++) begin
      in_valid_a[m]  = v;
      out_ready_a[m] = rdy;
    end
  endtask

  task automatic set_data(input int ch, input int val);
    for (int m = 0; m < 2; m++) in_data_a[m][ch*W +: W] = val;
  endtask

  // One clock: check in_ready before the edge, advance model, check outputs after
  task automatic cycle();
    int  g[2];
    bit  fr[2];
    logic [C-1:0] er;
    #1;
    for (int m = 0; m < 2; m++) begin
      g[m]  = model_grant(m);
      fr[m] = !m_vld[m] || out_ready_a[m];
      er    = '0;
      if (fr[m] && g[m] >= 0) er[g[m]] = 1'b1;
      check("in_ready", m, 32'(in_ready_a[m]), 32'(er));
      xfer_ch[m] = (fr[m] && g[m] >= 0) ? g[m] : -1;
    end
    @(posedge clk);
    if (rst_n) begin
      for (int m = 0; m < 2; m++) begin
        if (xfer_ch[m] >= 0) begin
          m_vld[m] = 1;
          m_dat[m] = chan_data(m, xfer_ch[m]);
          m_sel[m] = xfer_ch[m];
          m_ptr[m] = (xfer_ch[m] + 1) % C;
        end else if (fr[m]) begin
          m_vld[m] = 0;
        end
      end
    end else begin
      for (int m = 0; m < 2; m++) xfer_ch[m] = -1;
    end
    #1;
    for (int m = 0; m < 2; m++) begin
      check("out_valid", m, 32'(out_valid_a[m]), 32'(m_vld[m]));
      check("out_data",  m, out_data_a[m], 32'(m_dat[m]));
      check("out_sel",   m, 32'(out_sel_a[m]), 32'(m_sel[m]));
    end
    @(negedge clk);
  endtask

  int exp_rr_sel[6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    for (int m = 0; m < 2; m++) begin
      in_valid_a[m] = '0; in_data_a[m] = '0; out_ready_a[m] = 1'b0; xfer_ch[m] = -1;
    end
    model_reset();
    rst_n = 1'b0;

    // Reset held with random requests: grant visible on in_ready, outputs stay zero
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      set_all(C'($urandom_range(0, 15)), 1'b1);
      for (int i = 0; i < C; i++) set_data(i, int'($urandom));
      cycle();
    end
    rst_n = 1'b1;

    // Round-robin fairness with every channel requesting
    for (int i = 0; i < C; i++) set_data(i, 32'hA0 + i);
    set_all(4'b1111, 1'b1);
    for (int k = 0; k < 6; k++) begin
      cycle();
      check("rr_fair_sel",  0, 32'(out_sel_a[0]), 32'(exp_rr_sel[k]));
      check("rr_fair_data", 0, out_data_a[0], 32'hA0 + exp_rr_sel[k]);
      check("fp_all_sel",   1, 32'(out_sel_a[1]), 32'd0);
    end

    // Fixed priority: channel 1 always beats channel 3 until it drops
    set_data(1, 32'hB1); set_data(3, 32'hB3);
    set_all(4'b1010, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("fp_pri_sel", 1, 32'(out_sel_a[1]), 32'd1);
    end
    set_all(4'b1000, 1'b1);
    cycle();
    check("fp_drop_sel",  1, 32'(out_sel_a[1]), 32'd3);
    check("fp_drop_data", 1, out_data_a[1], 32'hB3);

    // Backpressure: 0x55 held three cycles, next beat loads on the drain cycle
    set_data(0, 32'h55);
    set_all(4'b0001, 1'b1);
    cycle();
    set_data(0, 32'h66);
    set_all(4'b0001, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("stall_data",  0, out_data_a[0], 32'h55);
      check("stall_ready", 1, 32'(in_ready_a[1]), 32'd0);
    end
    set_all(4'b0001, 1'b1);
    cycle();
    check("drain_load", 0, out_data_a[0], 32'h66);
    check("drain_load", 1, out_data_a[1], 32'h66);

    // Sparse request and pointer wrap: serve 2 (ptr=3), then lone 0, then ptr=1
    for (int i = 0; i < C; i++) set_data(i, 32'hC0 + i);
    set_all(4'b0100, 1'b1);
    cycle();
    set_all(4'b0001, 1'b1);
    cycle();
    check("wrap_sel", 0, 32'(out_sel_a[0]), 32'd0);
    set_all(4'b1111, 1'b1);
    cycle();
    check("ptr_after_wrap", 0, 32'(out_sel_a[0]), 32'd1);

    // Reset mid-stall: async clear of the held beat and the pointer
    set_all(4'b1111, 1'b0);
    cycle();
    #2 rst_n = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      check("async_rst_vld",  m, 32'(out_valid_a[m]), 32'd0);
      check("async_rst_data", m, out_data_a[m], 32'd0);
      check("async_rst_sel",  m, 32'(out_sel_a[m]), 32'd0);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    set_all(4'b1110, 1'b1);
    cycle();
    check("rst_ptr_zero", 0, 32'(out_sel_a[0]), 32'd1);
    set_all(4'b1111, 1'b1);
    cycle();
    check("rst_ptr_next", 0, 32'(out_sel_a[0]), 32'd2);

    // Randomized traffic; producers hold valid/data until their beat is taken
    for (int m = 0; m < 2; m++) in_valid_a[m] = '0;
    for (int k = 0; k < 400; k++) begin
      for (int m = 0; m < 2; m++) begin
        out_ready_a[m] = ($urandom_range(0, 3) != 0);
        for (int i = 0; i < C; i++) begin
          if (!in_valid_a[m][i] || xfer_ch[m] == i) begin
            in_valid_a[m][i] = $urandom_range(0, 1) != 0;
            in_data_a[m][i*W +: W] = $urandom;
          end
        end
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stream_mux_arb.md
# stream_mux_arb

Parametrised N-channel stream multiplexer with arbitration and a registered output. It replaces the purely combinational 2:1/4:1 selectors wherever several producers compete for one consumer, such as write-back sources, debug/bus requesters or memory-port sharing. Each input is a valid/ready stream. The block picks one valid channel per cycle, by round-robin or fixed priority, and presents it through a one-entry output register together with the index of the channel that won.

## Interface
- WIDTH, 32, data width per channel (≥1)
- CHANNELS, 4, number of input channels (≥1)
- MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins)
- SEL_W (local), CHANNELS>1 ? $clog2(CHANNELS) : 1, width of out_sel

- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  CHANNELS  per-channel valid, bit i = channel i
- in_data  in  CHANNELS*WIDTH  flattened data, channel i at [i*WIDTH +: WIDTH]
- in_ready  out  CHANNELS  per-channel ready, one-hot or zero
- out_valid  out  1  output register holds a beat
- out_data  out  WIDTH  registered data of the held beat
- out_sel  out  SEL_W  index of the channel that supplied the held beat
- out_ready  in  1  consumer accepts the held beat

## Operation
- Output register states: EMPTY when out_valid=0, FULL when out_valid=1.
- free = !out_valid | out_ready. The register can load in the same cycle it is drained.
- Arbitration is purely combinational over in_valid.
  - Grant goes to exactly one valid channel when at least one is valid.
  - MODE=1: the lowest set index wins.
  - MODE=0: the search starts at pointer ptr and wraps modulo CHANNELS.
- in_ready[i] = free & grant[i]. in_ready is zero when no channel is valid or when free=0.
- Transfer on channel i occurs when in_valid[i] & in_ready[i]. On the next edge:
  - out_data ← channel i data
  - out_sel ← i
  - out_valid ← 1
- When free=1 and no channel is valid, out_valid ← 0 on the next edge. out_data and out_sel keep their previous values.
- Round-robin pointer:
  - After a transfer from channel k, ptr ← (k+1) mod CHANNELS, with explicit wrap from CHANNELS-1 to 0.
  - ptr is unchanged when there is no transfer.
  - ptr is unused in MODE=1.
- Producer-side rule: once a producer asserts in_valid it holds in_valid and data until its transfer completes. A channel that is denied is not dropped; it re-competes in every cycle.
- Stall: while out_valid=1 and out_ready=0, out_data and out_sel are stable and all in_ready bits are 0.
- CHANNELS=1 degenerates to a registered pipeline stage with out_sel fixed at 0.

## Timing
- Reset (rst_n=0, async) sets out_valid=0, out_data=0, out_sel=0 and ptr=0. in_ready follows combinationally (all 0 while in_valid=0, otherwise the grant).
- Reset during a stall discards the held beat. The producer may re-present its data after reset.
- Latency is 1 cycle from input transfer to out_valid. Throughput is 1 beat per cycle when out_ready is held at 1.
- Combinational paths: in_valid→in_ready and out_ready→in_ready. There is no path from in_* or out_ready to out_valid, out_data or out_sel.
- Fairness in MODE=0: with all channels valid continuously and out_ready=1, each channel is granted exactly once every CHANNELS cycles.

## Structure
- Shared package holds the mode constants MODE_RR=0 and MODE_FIXED=1 and a clog2-style helper for SEL_W. The package is reused by future arbiters.
- Sub-module rr_arbiter (parameters CHANNELS, MODE) owns ptr and the grant logic:
  - inputs: req, advance (= transfer)
  - outputs: one-hot grant and grant index
- The top level contains the output register and the ready/valid glue.

## Test plan
- Reset: hold rst_n=0 with random in_valid → in_ready follows grant with no transfer, and out_valid=0, out_data=0, out_sel=0. After release, the first beat appears one cycle after its transfer.
- RR fairness: CHANNELS=4, MODE=0, all in_valid=1, data=0xA0+i, out_ready=1 → out_sel sequence 0,1,2,3,0,1 and out_data 0xA0,0xA1,0xA2,0xA3,0xA0.
- Fixed priority: MODE=1, in_valid=4'b1010 → only channel 1 is served, repeatedly. Dropping in_valid[1] → channel 3 is served next cycle.
- Backpressure: out_ready=0 for 3 cycles with a beat 0x55 held → out_data stays 0x55 and in_ready=0. Raising out_ready → 0x55 is consumed and the next beat loads in the same cycle.
- Sparse requests and wrap: MODE=0, ptr=3 after serving channel 2, only in_valid[0]=1 → grant to channel 0, then ptr=1.
- Reset mid-stall: assert rst_n=0 while FULL with out_ready=0 → out_valid drops immediately (async) and ptr returns to 0.
